// File: rtl/test_frame_gen.sv
// Timestamped, sequence-numbered Ethernet test frame source for the MAC TX sink.
// Define TEST_FRAME_GEN_PRBS_EN for PRBS-31 payload fill instead of a fixed pattern.
module test_frame_gen #(
   parameter logic [15:0] ETHERTYPE = 16'h88B5,
   parameter int          MIN_LEN   = 60,
   parameter int          MAX_LEN   = 1514
) (
   input  logic        clk_125m_i,
   input  logic        srst_i,
   input  logic        start_i,
   input  logic        stop_i,
   input  logic [10:0] frame_len_i,
   input  logic [15:0] gap_i,
   input  logic [31:0] count_i,
   input  logic [47:0] dst_mac_i,
   input  logic [47:0] src_mac_i,
   output logic [31:0] tx_data_o,
   output logic        tx_valid_o,
   output logic        tx_sop_o,
   output logic        tx_eop_o,
   output logic [1:0]  tx_empty_o,
   input  logic        tx_ready_i,
   output logic        busy_o,
   output logic [31:0] frames_sent_o
);

   typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

   state_t      state_q, state_d;
   logic [10:0] len_in, words_in, words_q, words_c;
   logic [1:0]  empty_in, empty_q, empty_c;
   logic [10:0] k_q, k_d;
   logic [15:0] gap_q, gcnt_q;
   logic [31:0] count_q, seq_q, fs_d, ts_q, ts_lat_q;
   logic [47:0] dst_q, src_q, dst_c, src_c;
   logic        stop_q, acc, eop_acc, done, load, clear, last;
   logic [31:0] word, fill;

   // Clamp the requested length, then derive beat count and EOP empty bytes
   always_comb begin
      len_in = frame_len_i;
      if (frame_len_i < 11'(MIN_LEN))
         len_in = 11'(MIN_LEN);
      else if (frame_len_i > 11'(MAX_LEN))
         len_in = 11'(MAX_LEN);
   end

   assign words_in = (len_in + 11'd3) >> 2;
   assign empty_in = ~len_in[1:0] + 2'd1;

   assign acc     = tx_valid_o & tx_ready_i;
   assign eop_acc = acc & tx_eop_o;

   assign fs_d = (eop_acc && frames_sent_o != '1)
               ? frames_sent_o + 32'd1 : frames_sent_o;

   assign done = stop_q | stop_i
               | ((count_q != 32'd0) && (fs_d == count_q));

   // Config comes straight from the inputs on the start cycle
   always_comb begin
      dst_c   = dst_q;
      src_c   = src_q;
      words_c = words_q;
      empty_c = empty_q;
      if (state_q == IDLE) begin
         dst_c   = dst_mac_i;
         src_c   = src_mac_i;
         words_c = words_in;
         empty_c = empty_in;
      end
   end

   always_comb begin
      state_d = state_q;
      load    = 1'b0;
      clear   = 1'b0;
      k_d     = k_q;
      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = SEND;
               load    = 1'b1;
               k_d     = 11'd0;
            end
         end
         SEND: begin
            if (acc) begin
               if (!tx_eop_o) begin
                  load = 1'b1;
                  k_d  = k_q + 11'd1;
               end else if (gap_q != 16'd0) begin
                  state_d = GAP;
                  clear   = 1'b1;
               end else if (done) begin
                  state_d = IDLE;
                  clear   = 1'b1;
               end else begin
                  load = 1'b1;
                  k_d  = 11'd0;
               end
            end
         end
         GAP: begin
            if (gcnt_q == 16'd0) begin
               if (done) begin
                  state_d = IDLE;
                  clear   = 1'b1;
               end else begin
                  state_d = SEND;
                  load    = 1'b1;
                  k_d     = 11'd0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign last = (k_d == words_c - 11'd1);

`ifdef TEST_FRAME_GEN_PRBS_EN
   logic [30:0] lfsr_q;
   logic [62:0] prbs;

   // 32 serial steps of x^31 + x^28 + 1; returns {next state, word}
   function automatic logic [62:0] prbs_step(input logic [30:0] s);
      logic [30:0] r;
      logic [31:0] w;
      r = s;
      w = '0;
      for (int i = 0; i < 32; i++) begin
         w = {w[30:0], r[30] ^ r[27]};
         r = {r[29:0], r[30] ^ r[27]};
      end
      return {r, w};
   endfunction

   assign prbs = prbs_step(lfsr_q);
   assign fill = prbs[31:0];

   always_ff @(posedge clk_125m_i) begin
      if (srst_i)
         lfsr_q <= '1;
      else if (load && k_d == 11'd0)
         lfsr_q <= '1;
      else if (load && k_d >= 11'd6)
         lfsr_q <= prbs[62:32];
   end
`else
   assign fill = {16'hA5A5, 5'd0, k_d};
`endif

   always_comb begin
      word = '0;
      unique case (1'b1)
         (k_d == 11'd0): word = dst_c[47:16];
         (k_d == 11'd1): word = {dst_c[15:0], src_c[47:32]};
         (k_d == 11'd2): word = src_c[31:0];
         (k_d == 11'd3): word = {ETHERTYPE, 16'h0000};
         (k_d == 11'd4): word = seq_q;
         (k_d == 11'd5): word = ts_lat_q;
         (k_d >= 11'd6): word = fill;
      endcase
   end

   always_ff @(posedge clk_125m_i) begin
      if (srst_i)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   always_ff @(posedge clk_125m_i) begin
      if (srst_i) begin
         tx_data_o     <= '0;
         tx_valid_o    <= 1'b0;
         tx_sop_o      <= 1'b0;
         tx_eop_o      <= 1'b0;
         tx_empty_o    <= '0;
         busy_o        <= 1'b0;
         frames_sent_o <= '0;
         ts_q          <= '0;
         ts_lat_q      <= '0;
         seq_q         <= '0;
         stop_q        <= 1'b0;
         k_q           <= '0;
         gcnt_q        <= '0;
         words_q       <= '0;
         empty_q       <= '0;
         gap_q         <= '0;
         count_q       <= '0;
         dst_q         <= '0;
         src_q         <= '0;
      end else begin
         ts_q   <= ts_q + 32'd1;
         busy_o <= (state_d != IDLE);
         if (state_q == IDLE && start_i) begin
            words_q       <= words_in;
            empty_q       <= empty_in;
            gap_q         <= gap_i;
            count_q       <= count_i;
            dst_q         <= dst_mac_i;
            src_q         <= src_mac_i;
            seq_q         <= '0;
            frames_sent_o <= '0;
            stop_q        <= 1'b0;
         end else begin
            frames_sent_o <= fs_d;
            if (eop_acc)
               seq_q <= seq_q + 32'd1;
            if (state_d == IDLE)
               stop_q <= 1'b0;
            else if (stop_i && state_q != IDLE)
               stop_q <= 1'b1;
         end
         if (acc && tx_sop_o)
            ts_lat_q <= ts_q;
         if (state_q == SEND && state_d == GAP)
            gcnt_q <= gap_q - 16'd1;
         else if (state_q == GAP)
            gcnt_q <= gcnt_q - 16'd1;
         if (load) begin
            k_q        <= k_d;
            tx_valid_o <= 1'b1;
            tx_data_o  <= word;
            tx_sop_o   <= (k_d == 11'd0);
            tx_eop_o   <= last;
            tx_empty_o <= last ? empty_c : 2'd0;
         end else if (clear) begin
            tx_valid_o <= 1'b0;
            tx_data_o  <= '0;
            tx_sop_o   <= 1'b0;
            tx_eop_o   <= 1'b0;
            tx_empty_o <= '0;
         end
      end
   end

endmodule

// File: tb/tb_test_frame_gen.sv
// Directed bench for test_frame_gen: framing, clamp, backpressure,
// gap/sequence, stop and mid-frame reset.
module tb_test_frame_gen;

   localparam logic [47:0] DST = 48'h0011_2233_4455;
   localparam logic [47:0] SRC = 48'h6677_8899_AABB;

   logic        clk_125m_i = 1'b0;
   logic        srst_i, start_i, stop_i, tx_ready_i;
   logic [10:0] frame_len_i;
   logic [15:0] gap_i;
   logic [31:0] count_i;
   logic [47:0] dst_mac_i, src_mac_i;
   logic [31:0] tx_data_o;
   logic        tx_valid_o, tx_sop_o, tx_eop_o;
   logic [1:0]  tx_empty_o;
   logic        busy_o;
   logic [31:0] frames_sent_o;

   int errors = 0;
   int checks = 0;

   logic [31:0] tb_ts;
   logic [31:0] b_data[$];
   logic        b_sop[$];
   logic        b_eop[$];
   logic [1:0]  b_emp[$];
   logic [31:0] b_ts[$];
   logic [31:0] idle_ts;
   int          stall_bad, stalls;
   bit          tmo;

   test_frame_gen dut (
      .clk_125m_i   (clk_125m_i),
      .srst_i       (srst_i),
      .start_i      (start_i),
      .stop_i       (stop_i),
      .frame_len_i  (frame_len_i),
      .gap_i        (gap_i),
      .count_i      (count_i),
      .dst_mac_i    (dst_mac_i),
      .src_mac_i    (src_mac_i),
      .tx_data_o    (tx_data_o),
      .tx_valid_o   (tx_valid_o),
      .tx_sop_o     (tx_sop_o),
      .tx_eop_o     (tx_eop_o),
      .tx_empty_o   (tx_empty_o),
      .tx_ready_i   (tx_ready_i),
      .busy_o       (busy_o),
      .frames_sent_o(frames_sent_o)
   );

   always #4 clk_125m_i = ~clk_125m_i;

   // Reference cycle counter, reset and free-running like the launch clock
   always @(posedge clk_125m_i) begin
      if (srst_i) tb_ts <= '0;
      else        tb_ts <= tb_ts + 32'd1;
   end

   task automatic start_burst(input logic [10:0] len,
                              input logic [15:0] gap,
                              input logic [31:0] cnt);
      frame_len_i = len;
      gap_i       = gap;
      count_i     = cnt;
      start_i     = 1'b1;
      @(negedge clk_125m_i);
      start_i     = 1'b0;
   endtask

   // Records accepted beats until busy drops; optionally pulses stop
   // alongside the EOP of frame stop_frame
   task automatic collect(input int max_cyc, input bit rnd,
                          input int stop_frame, output bit to);
      bit          seen = 1'b0;
      bit          pstall = 1'b0;
      logic [36:0] prev = '0;
      int          eops = 0;
      b_data.delete(); b_sop.delete(); b_eop.delete();
      b_emp.delete();  b_ts.delete();
      stall_bad = 0;
      stalls    = 0;
      to        = 1'b1;
      for (int i = 0; i < max_cyc; i++) begin
         if (pstall && {tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, tx_empty_o} !== prev)
            stall_bad++;
         if (busy_o) seen = 1'b1;
         if (seen && !busy_o) begin
            idle_ts = tb_ts;
            to = 1'b0;
            break;
         end
         tx_ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         stop_i = 1'b0;
         if (tx_valid_o && tx_ready_i) begin
            b_data.push_back(tx_data_o);
            b_sop.push_back(tx_sop_o);
            b_eop.push_back(tx_eop_o);
            b_emp.push_back(tx_empty_o);
            b_ts.push_back(tb_ts);
            if (tx_eop_o) begin
               eops++;
               if (eops == stop_frame) stop_i = 1'b1;
            end
         end
         pstall = tx_valid_o && !tx_ready_i;
         if (pstall) stalls++;
         prev = {tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, tx_empty_o};
         @(negedge clk_125m_i);
      end
      stop_i = 1'b0;
      tx_ready_i = 1'b1;
   endtask

   task automatic test_reset;
      checks++;
      if ({tx_valid_o, tx_sop_o, tx_eop_o, tx_empty_o} !== 5'b0) begin
         errors++;
         $display("FAIL rst_flags: got %b want 00000", {tx_valid_o, tx_sop_o, tx_eop_o, tx_empty_o});
      end
      checks++;
      if (tx_data_o !== 32'h0) begin
         errors++; $display("FAIL rst_data: got %h want 0", tx_data_o);
      end
      checks++;
      if (busy_o !== 1'b0 || frames_sent_o !== 32'd0) begin
         errors++; $display("FAIL rst_busy_fs: got %b/%0d want 0/0", busy_o, frames_sent_o);
      end
      srst_i = 1'b0;
      @(negedge clk_125m_i);
   endtask

   task automatic test_min_frame;
      int nsop = 0, neop = 0, nemp = 0;
      start_burst(11'd64, 16'd0, 32'd1);
      checks++;
      if (tx_valid_o !== 1'b1 || tx_sop_o !== 1'b1 || busy_o !== 1'b1) begin
         errors++; $display("FAIL min_latency: got v%b s%b b%b want 111", tx_valid_o, tx_sop_o, busy_o);
      end
      collect(200, 1'b0, 0, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL min_timeout: busy still high want low"); end
      checks++;
      if (b_data.size() != 16) begin
         errors++; $display("FAIL min_beats: got %0d want 16", b_data.size());
      end else begin
         foreach (b_sop[i]) begin
            nsop += int'(b_sop[i]);
            neop += int'(b_eop[i]);
            if (!b_eop[i] && b_emp[i] != 2'd0) nemp++;
         end
         checks++;
         if (b_sop[0] !== 1'b1 || b_eop[15] !== 1'b1 || nsop != 1 || neop != 1) begin
            errors++; $display("FAIL min_flags: got sop%0d eop%0d want 1/1 at k0/k15", nsop, neop);
         end
         checks++;
         if (b_emp[15] !== 2'd0 || nemp != 0) begin
            errors++; $display("FAIL min_empty: got %0d (%0d bad) want 0", b_emp[15], nemp);
         end
         checks++;
         if (b_data[0] !== 32'h0011_2233 || b_data[1] !== 32'h4455_6677 ||
             b_data[2] !== 32'h8899_AABB) begin
            errors++; $display("FAIL min_mac: got %h %h %h want 00112233 44556677 8899aabb",
                               b_data[0], b_data[1], b_data[2]);
         end
         checks++;
         if (b_data[3] !== 32'h88B5_0000) begin
            errors++; $display("FAIL min_ethertype: got %h want 88b50000", b_data[3]);
         end
         checks++;
         if (b_data[4] !== 32'd0) begin
            errors++; $display("FAIL min_seq: got %h want 0", b_data[4]);
         end
         checks++;
         if (b_data[5] !== b_ts[0]) begin
            errors++; $display("FAIL min_ts: got %h want %h", b_data[5], b_ts[0]);
         end
         checks++;
         if (b_data[6] !== 32'hA5A5_0006 || b_data[15] !== 32'hA5A5_000F) begin
            errors++; $display("FAIL min_fill: got %h %h want a5a50006 a5a5000f", b_data[6], b_data[15]);
         end
         checks++;
         if (b_ts[15] - b_ts[0] != 32'd15 || idle_ts - b_ts[15] != 32'd1) begin
            errors++; $display("FAIL min_timing: got span %0d idle %0d want 15/1",
                               b_ts[15] - b_ts[0], idle_ts - b_ts[15]);
         end
      end
      checks++;
      if (frames_sent_o !== 32'd1 || busy_o !== 1'b0) begin
         errors++; $display("FAIL min_done: got fs%0d busy%b want 1/0", frames_sent_o, busy_o);
      end
   endtask

   task automatic test_clamp;
      start_burst(11'd10, 16'd0, 32'd1);
      collect(200, 1'b0, 0, tmo);
      checks++;
      if (tmo || b_data.size() != 15) begin
         errors++; $display("FAIL clamp_lo_beats: got %0d want 15", b_data.size());
      end else begin
         checks++;
         if (b_eop[14] !== 1'b1 || b_emp[14] !== 2'd0) begin
            errors++; $display("FAIL clamp_lo_eop: got eop%b empty%0d want 1/0", b_eop[14], b_emp[14]);
         end
      end
      start_burst(11'd2000, 16'd0, 32'd1);
      collect(1000, 1'b0, 0, tmo);
      checks++;
      if (tmo || b_data.size() != 379) begin
         errors++; $display("FAIL clamp_hi_beats: got %0d want 379", b_data.size());
      end else begin
         checks++;
         if (b_eop[378] !== 1'b1 || b_emp[378] !== 2'd2) begin
            errors++; $display("FAIL clamp_hi_eop: got eop%b empty%0d want 1/2", b_eop[378], b_emp[378]);
         end
         checks++;
         if (b_data[378] !== 32'hA5A5_017A || b_emp[377] !== 2'd0) begin
            errors++; $display("FAIL clamp_hi_last: got %h/%0d want a5a5017a/0", b_data[378], b_emp[377]);
         end
      end
   endtask

   task automatic test_back_to_back;
      start_burst(11'd64, 16'd0, 32'd2);
      collect(300, 1'b0, 0, tmo);
      checks++;
      if (tmo || b_data.size() != 32) begin
         errors++; $display("FAIL b2b_beats: got %0d want 32", b_data.size());
      end else begin
         checks++;
         if (b_sop[16] !== 1'b1 || b_ts[16] - b_ts[15] != 32'd1) begin
            errors++; $display("FAIL b2b_sop: got sop%b dist %0d want 1/1", b_sop[16], b_ts[16] - b_ts[15]);
         end
         checks++;
         if (b_data[20] !== 32'd1 || b_data[21] !== b_ts[16]) begin
            errors++; $display("FAIL b2b_seq_ts: got %h %h want 1 %h", b_data[20], b_data[21], b_ts[16]);
         end
      end
      checks++;
      if (frames_sent_o !== 32'd2) begin
         errors++; $display("FAIL b2b_fs: got %0d want 2", frames_sent_o);
      end
   endtask

   task automatic test_backpressure;
      start_burst(11'd67, 16'd0, 32'd1);
      collect(2000, 1'b1, 0, tmo);
      checks++;
      if (tmo || b_data.size() != 17) begin
         errors++; $display("FAIL bp_beats: got %0d want 17", b_data.size());
      end else begin
         checks++;
         if (b_eop[16] !== 1'b1 || b_emp[16] !== 2'd1) begin
            errors++; $display("FAIL bp_eop: got eop%b empty%0d want 1/1", b_eop[16], b_emp[16]);
         end
         checks++;
         if (b_data[5] !== b_ts[0]) begin
            errors++; $display("FAIL bp_ts: got %h want %h", b_data[5], b_ts[0]);
         end
         checks++;
         if (b_data[4] !== 32'd0 || b_data[16] !== 32'hA5A5_0010) begin
            errors++; $display("FAIL bp_data: got %h %h want 0 a5a50010", b_data[4], b_data[16]);
         end
      end
      checks++;
      if (stall_bad != 0) begin
         errors++; $display("FAIL bp_stable: got %0d changes in %0d stalls want 0", stall_bad, stalls);
      end
   endtask

   task automatic test_gap_seq;
      start_burst(11'd64, 16'd5, 32'd3);
      collect(500, 1'b0, 0, tmo);
      checks++;
      if (tmo || b_data.size() != 48) begin
         errors++; $display("FAIL gap_beats: got %0d want 48", b_data.size());
      end else begin
         checks++;
         if (b_data[4] !== 32'd0 || b_data[20] !== 32'd1 || b_data[36] !== 32'd2) begin
            errors++; $display("FAIL gap_seq: got %h %h %h want 0 1 2", b_data[4], b_data[20], b_data[36]);
         end
         checks++;
         if (b_ts[16] - b_ts[15] != 32'd6 || b_ts[32] - b_ts[31] != 32'd6) begin
            errors++; $display("FAIL gap_idle: got %0d %0d want 6 6 (5 idle)",
                               b_ts[16] - b_ts[15], b_ts[32] - b_ts[31]);
         end
         checks++;
         if (idle_ts - b_ts[47] != 32'd6) begin
            errors++; $display("FAIL gap_busy_fall: got %0d want 6", idle_ts - b_ts[47]);
         end
      end
      checks++;
      if (frames_sent_o !== 32'd3) begin
         errors++; $display("FAIL gap_fs: got %0d want 3", frames_sent_o);
      end
   endtask

   task automatic test_stop;
      int vcnt = 0;
      start_burst(11'd64, 16'd3, 32'd0);
      collect(500, 1'b0, 2, tmo);
      checks++;
      if (tmo || b_data.size() != 32) begin
         errors++; $display("FAIL stop_beats: got %0d want 32", b_data.size());
      end else begin
         checks++;
         if (idle_ts - b_ts[31] != 32'd4) begin
            errors++; $display("FAIL stop_idle: got %0d want 4", idle_ts - b_ts[31]);
         end
      end
      repeat (20) begin
         if (tx_valid_o || busy_o) vcnt++;
         @(negedge clk_125m_i);
      end
      checks++;
      if (vcnt != 0 || frames_sent_o !== 32'd2) begin
         errors++; $display("FAIL stop_quiet: got %0d active fs%0d want 0/2", vcnt, frames_sent_o);
      end
   endtask

   task automatic test_reset_mid;
      start_burst(11'd64, 16'd0, 32'd0);
      repeat (7) @(negedge clk_125m_i);
      checks++;
      if (tx_data_o !== 32'hA5A5_0007) begin
         errors++; $display("FAIL rstm_beat7: got %h want a5a50007", tx_data_o);
      end
      srst_i = 1'b1;
      @(negedge clk_125m_i);
      checks++;
      if ({tx_data_o, tx_valid_o, tx_sop_o, tx_eop_o, tx_empty_o, busy_o} !== 38'b0 ||
          frames_sent_o !== 32'd0) begin
         errors++; $display("FAIL rstm_zero: got d%h v%b b%b fs%0d want all 0",
                            tx_data_o, tx_valid_o, busy_o, frames_sent_o);
      end
      srst_i = 1'b0;
      @(negedge clk_125m_i);
      start_burst(11'd64, 16'd0, 32'd1);
      collect(200, 1'b0, 0, tmo);
      checks++;
      if (tmo || b_data.size() != 16) begin
         errors++; $display("FAIL rstm_restart: got %0d want 16", b_data.size());
      end else begin
         checks++;
         if (b_data[4] !== 32'd0 || b_data[5] !== b_ts[0]) begin
            errors++; $display("FAIL rstm_hdr: got %h %h want 0 %h", b_data[4], b_data[5], b_ts[0]);
         end
      end
   endtask

   initial begin
      srst_i      = 1'b1;
      start_i     = 1'b0;
      stop_i      = 1'b0;
      tx_ready_i  = 1'b1;
      frame_len_i = 11'd64;
      gap_i       = 16'd0;
      count_i     = 32'd0;
      dst_mac_i   = DST;
      src_mac_i   = SRC;
      repeat (3) @(negedge clk_125m_i);
      test_reset;
      test_min_frame;
      test_clamp;
      test_back_to_back;
      test_backpressure;
      test_gap_seq;
      test_stop;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/test_frame_gen.md
# test_frame_gen

Generates timestamped, sequence-numbered Ethernet test frames and feeds them to the TX Avalon-ST sink of the delay-tester MAC. It sits directly upstream of the MAC in the 125 MHz system clock domain, under control of the system CSR logic. Each frame carries:
- a 32-bit sequence number;
- a 32-bit launch timestamp, which the RX-side checker uses for latency measurement.

The MAC appends preamble and FCS; this block produces only the header and payload.

## Interface
Parameters:
- ETHERTYPE, 16'h88B5, EtherType written into every frame.
- MIN_LEN, 60, minimum frame length in bytes, excluding FCS.
- MAX_LEN, 1514, maximum frame length in bytes, excluding FCS.

Ports:
- Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk_125m_i  in  1  system/MAC TX clock.
- srst_i  in  1  synchronous active-high reset.
- start_i  in  1  one-cycle pulse; latches the config inputs and starts a burst.
- stop_i  in  1  one-cycle pulse; ends the burst after the current frame completes.
- frame_len_i  in  11  frame length in bytes.
- gap_i  in  16  idle cycles between the EOP beat and the next SOP beat.
- count_i  in  32  frames per burst; 0 = continuous until stop_i.
- dst_mac_i  in  48  destination MAC address.
- src_mac_i  in  48  source MAC address.
- tx_data_o  out  32  Avalon-ST data, first byte in [31:24].
- tx_valid_o  out  1  Avalon-ST valid.
- tx_sop_o  out  1  start of packet.
- tx_eop_o  out  1  end of packet.
- tx_empty_o  out  2  unused bytes in the EOP word.
- tx_ready_i  in  1  Avalon-ST ready, readyLatency 0.
- busy_o  out  1  high from the start_i acceptance until return to IDLE.
- frames_sent_o  out  32  frames completed since the last start_i.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE → SEND on start_i.
  - On this transition, latch frame_len_i, gap_i, count_i, dst_mac_i and src_mac_i.
  - Clear the sequence number and frames_sent_o.
- start_i is ignored outside IDLE.
- Length clamp: L = max(MIN_LEN, min(MAX_LEN, frame_len_i)).
  - Word count W = ceil(L/4).
  - EOP empty = (4 − L mod 4) mod 4.
- Word layout, big-endian byte order, word index k:
  - k0: dst[47:16]
  - k1: {dst[15:0], src[47:32]}
  - k2: src[31:0]
  - k3: {ETHERTYPE, 16'h0000}
  - k4: sequence number
  - k5: timestamp
  - k≥6: fill (see Configuration)
- Timestamp: a free-running 32-bit cycle counter, reset to 0, incrementing every cycle and wrapping at 2^32.
  - The value is sampled in the cycle the k0 beat is accepted (valid & ready).
- A beat is accepted when tx_valid_o & tx_ready_i.
  - The word index advances only on acceptance.
  - All tx_* outputs are held stable while valid & !ready.
- SEND → GAP on acceptance of the EOP beat. In that same cycle:
  - frames_sent_o increments.
  - The sequence number increments, wrapping at 2^32.
- GAP counts gap_i cycles with tx_valid_o low.
  - gap_i = 0 means the next SOP is presented in the cycle immediately after the EOP acceptance.
- End of GAP:
  - Go to IDLE if a stop is pending, or if count_i ≠ 0 and frames_sent_o == count_i.
  - Otherwise go to SEND.
- stop_i arriving in any non-IDLE state sets a pending flag. The frame in progress is never truncated.
  - If stop_i and EOP acceptance coincide, the burst still ends after that frame.
- count_i = 1 sends exactly one frame.
- frames_sent_o saturates at 2^32−1 in continuous mode.

## Timing
- Reset values:
  - tx_data_o = 0, tx_valid_o = 0, tx_sop_o = 0, tx_eop_o = 0, tx_empty_o = 0.
  - busy_o = 0, frames_sent_o = 0.
  - FSM = IDLE; timestamp counter = 0; stop-pending flag cleared.
- srst_i asserted mid-frame: all outputs take their reset values on the next edge. The partial frame is abandoned with no EOP; the MAC is reset by the same srst_i.
- Outputs are registered.
  - The first SOP beat is valid 1 cycle after start_i is sampled.
  - busy_o rises in that same cycle.
- With tx_ready_i held high, a frame occupies exactly W cycles.
  - Frame period = W + gap_i cycles.
- busy_o falls in the cycle the FSM enters IDLE.
- tx_empty_o is 0 on every beat except EOP.

## Configuration
- Macro TEST_FRAME_GEN_PRBS_EN.
- Defined:
  - Fill words k≥6 come from a 32-bit-per-cycle PRBS-31 generator (x^31 + x^28 + 1).
  - The generator is seeded with 31'h7FFF_FFFF at each SOP and advances on each accepted fill beat.
- Not defined:
  - Fill word k = {16'hA5A5, k[15:0]}.
  - No LFSR logic is synthesised.

## Test plan
- Minimum-length frame:
  - Stimulus: frame_len_i = 64, count_i = 1, gap_i = 0, ready always high.
  - Response: 16 beats; SOP on k0; EOP on k15 with empty = 0; k3 = 32'h88B5_0000; k4 = 0; frames_sent_o = 1; busy_o falls.
- Length clamping:
  - Stimulus: frame_len_i = 10, then frame_len_i = 2000.
  - Response: 15 beats with empty = 0; then 379 beats with EOP empty = 2.
- Backpressure:
  - Stimulus: frame_len_i = 67; ready toggled pseudo-randomly.
  - Response: data and flags stable while stalled; 17 accepted beats, EOP empty = 1; k5 equals the counter value at the cycle k0 was accepted.
- Gap and sequence:
  - Stimulus: count_i = 3, gap_i = 5, frame_len_i = 64.
  - Response: k4 = 0, 1, 2 across the frames; exactly 5 idle cycles between EOP and the next SOP; frames_sent_o = 3.
- Stop and reset:
  - Stimulus: count_i = 0; stop_i asserted in the EOP cycle of frame 2.
  - Response: no frame 3; return to IDLE after the gap.
  - Stimulus: separate run with srst_i asserted on beat 7.
  - Response: all outputs 0 on the next cycle.
